// File: rtl/branch_resolve_sequencer_if.sv
// Bundle of fetch, resolve and predictor-update signals for
// branch_resolve_sequencer.
//   slave  : the sequencer (consumes fetch/resolve, drives update/redirect)
//   master : the surrounding pipeline / testbench
// pipeline_en rides in the bundle because every side sees it.
interface branch_resolve_sequencer_if #(
  parameter int DEPTH = 4,
  parameter int CNT_W = $clog2(DEPTH) + 1
);
  logic             pipeline_en;
  logic             fetch_valid;
  logic [31:0]      fetch_pc;
  logic             fetch_pred_taken;
  logic [31:0]      fetch_pred_target;
  logic             fetch_ready;
  logic             resolve_valid;
  logic             resolve_taken;
  logic [31:0]      resolve_target;
  logic             upd_valid;
  logic [31:0]      upd_pc;
  logic             upd_taken;
  logic             mispredict;
  logic [31:0]      redirect_pc;
  logic [CNT_W-1:0] count;
  logic             underflow_err;

  modport slave (
    input  pipeline_en, fetch_valid, fetch_pc, fetch_pred_taken, fetch_pred_target,
           resolve_valid, resolve_taken, resolve_target,
    output fetch_ready, upd_valid, upd_pc, upd_taken, mispredict, redirect_pc,
           count, underflow_err
  );

  modport master (
    output pipeline_en, fetch_valid, fetch_pc, fetch_pred_taken, fetch_pred_target,
           resolve_valid, resolve_taken, resolve_target,
    input  fetch_ready, upd_valid, upd_pc, upd_taken, mispredict, redirect_pc,
           count, underflow_err
  );
endinterface

// File: rtl/branch_resolve_sequencer.sv
// branch_resolve_sequencer: in-order queue of predicted branches between
// fetch/decode and execute. Each resolve of the oldest entry issues one
// registered predictor update; a wrong direction or target raises a one-cycle
// redirect, flushes all younger entries and blocks fetch for one cycle.
// Ports:
//   clk, reset : clock, synchronous active-high reset
//   bus        : branch_resolve_sequencer_if.slave (fetch push, resolve pop,
//                update strobe, redirect, occupancy, sticky underflow flag)
module branch_resolve_sequencer #(
  parameter int DEPTH = 4,
  parameter int CNT_W = $clog2(DEPTH) + 1
) (
  input logic                        clk,
  input logic                        reset,
  branch_resolve_sequencer_if.slave  bus
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [0:0] RUN   = 1'b0;
  localparam logic [0:0] FLUSH = 1'b1;

  logic [0:0]       state;
  logic [AW-1:0]    head, tail;
  logic [CNT_W-1:0] count_q;

  logic [31:0] pc_mem  [DEPTH];
  logic        pt_mem  [DEPTH];
  logic [31:0] tgt_mem [DEPTH];

  logic        push, pop, empty_pop, mis;
  logic [31:0] head_pc, head_tgt;
  logic        head_pt;

  assign head_pc  = pc_mem[head];
  assign head_pt  = pt_mem[head];
  assign head_tgt = tgt_mem[head];

  assign bus.fetch_ready = (state == RUN) && (count_q != CNT_W'(DEPTH));
  assign bus.count       = count_q;

  assign push      = bus.fetch_valid && bus.fetch_ready && bus.pipeline_en;
  assign pop       = bus.resolve_valid && bus.pipeline_en && (count_q != '0);
  assign empty_pop = bus.resolve_valid && bus.pipeline_en && (count_q == '0);
  // Target only matters when the branch actually went taken.
  assign mis = pop && ((bus.resolve_taken != head_pt) ||
                       (bus.resolve_taken && (bus.resolve_target != head_tgt)));

  // Entry storage needs no reset: occupancy tracking decides what is valid.
  // A push coinciding with a mispredict is wrong-path and is dropped.
  always_ff @(posedge clk) begin
    if (!reset && push && !mis) begin
      pc_mem[tail]  <= bus.fetch_pc;
      pt_mem[tail]  <= bus.fetch_pred_taken;
      tgt_mem[tail] <= bus.fetch_pred_target;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state             <= RUN;
      head              <= '0;
      tail              <= '0;
      count_q           <= '0;
      bus.upd_valid     <= 1'b0;
      bus.upd_pc        <= '0;
      bus.upd_taken     <= 1'b0;
      bus.mispredict    <= 1'b0;
      bus.redirect_pc   <= '0;
      bus.underflow_err <= 1'b0;
    end else begin
      bus.upd_valid  <= pop;
      bus.mispredict <= mis;
      if (pop) begin
        bus.upd_pc    <= head_pc;
        bus.upd_taken <= bus.resolve_taken;
      end
      if (mis)
        bus.redirect_pc <= bus.resolve_taken ? bus.resolve_target : head_pc + 32'd4;
      if (empty_pop)
        bus.underflow_err <= 1'b1;

      // FLUSH lasts one advancing cycle; it stalls with the pipeline.
      if (bus.pipeline_en && state == FLUSH)
        state <= RUN;

      if (mis) begin
        head    <= '0;
        tail    <= '0;
        count_q <= '0;
        state   <= FLUSH;
      end else begin
        if (push) tail <= tail + 1'b1;
        if (pop)  head <= head + 1'b1;
        case ({push, pop})
          2'b10:   count_q <= count_q + 1'b1;
          2'b01:   count_q <= count_q - 1'b1;
          default: count_q <= count_q;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_branch_resolve_sequencer.sv
module tb_branch_resolve_sequencer;
  logic clk = 1'b0;
  logic reset;
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  branch_resolve_sequencer_if #(.DEPTH(4)) bus ();

  branch_resolve_sequencer #(.DEPTH(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic fetch(input logic v, input logic [31:0] pc, input logic pt, input logic [31:0] tgt);
    bus.fetch_valid       = v;
    bus.fetch_pc          = pc;
    bus.fetch_pred_taken  = pt;
    bus.fetch_pred_target = tgt;
  endtask

  task automatic resolve(input logic v, input logic t, input logic [31:0] tgt);
    bus.resolve_valid  = v;
    bus.resolve_taken  = t;
    bus.resolve_target = tgt;
  endtask

  task automatic chk_upd(input string tag, input logic v, input logic [31:0] pc,
                         input logic t, input logic [31:0] cnt);
    chk({tag, ".upd_valid"}, 32'(bus.upd_valid), 32'(v));
    if (v) begin
      chk({tag, ".upd_pc"}, bus.upd_pc, pc);
      chk({tag, ".upd_taken"}, 32'(bus.upd_taken), 32'(t));
    end
    chk({tag, ".count"}, 32'(bus.count), cnt);
  endtask

  initial begin
    reset = 1'b1;
    bus.pipeline_en = 1'b1;
    fetch(1'b0, '0, 1'b0, '0);
    resolve(1'b0, 1'b0, '0);
    tick(); tick();
    reset = 1'b0;
    chk("rst.upd_valid", 32'(bus.upd_valid), 0);
    chk("rst.mispredict", 32'(bus.mispredict), 0);
    chk("rst.redirect", bus.redirect_pc, 0);
    chk("rst.count", 32'(bus.count), 0);
    chk("rst.underflow", 32'(bus.underflow_err), 0);
    chk("rst.ready", 32'(bus.fetch_ready), 1);

    // correct not-taken
    fetch(1'b1, 32'h100, 1'b0, 32'h0); tick(); fetch(1'b0, '0, 1'b0, '0);
    chk("t1.count", 32'(bus.count), 1);
    resolve(1'b1, 1'b0, 32'h0); tick(); resolve(1'b0, 1'b0, '0);
    chk_upd("t1", 1'b1, 32'h100, 1'b0, 0);
    chk("t1.mispredict", 32'(bus.mispredict), 0);
    tick();
    chk("t1.upd_once", 32'(bus.upd_valid), 0);

    // wrong target -> redirect, FLUSH blocks a fetch for one cycle
    fetch(1'b1, 32'h200, 1'b1, 32'h240); tick(); fetch(1'b0, '0, 1'b0, '0);
    resolve(1'b1, 1'b1, 32'h280); tick(); resolve(1'b0, 1'b0, '0);
    chk_upd("t2", 1'b1, 32'h200, 1'b1, 0);
    chk("t2.mispredict", 32'(bus.mispredict), 1);
    chk("t2.redirect", bus.redirect_pc, 32'h280);
    chk("t2.ready_flush", 32'(bus.fetch_ready), 0);
    fetch(1'b1, 32'h999, 1'b0, 32'h0); tick(); fetch(1'b0, '0, 1'b0, '0);
    chk("t2.ready_run", 32'(bus.fetch_ready), 1);
    chk("t2.flush_drop", 32'(bus.count), 0);
    chk("t2.mis_clear", 32'(bus.mispredict), 0);
    chk("t2.redirect_hold", bus.redirect_pc, 32'h280);

    // wrong direction on oldest of three -> flush younger
    fetch(1'b1, 32'h300, 1'b1, 32'h340); tick();
    fetch(1'b1, 32'h304, 1'b1, 32'h344); tick();
    fetch(1'b1, 32'h308, 1'b1, 32'h348); tick();
    fetch(1'b0, '0, 1'b0, '0);
    chk("t3.count3", 32'(bus.count), 3);
    resolve(1'b1, 1'b0, 32'h0); tick(); resolve(1'b0, 1'b0, '0);
    chk_upd("t3", 1'b1, 32'h300, 1'b0, 0);
    chk("t3.mispredict", 32'(bus.mispredict), 1);
    chk("t3.redirect", bus.redirect_pc, 32'h304);
    tick();
    chk("t3.no_upd_a", 32'(bus.upd_valid), 0);
    tick();
    chk("t3.no_upd_b", 32'(bus.upd_valid), 0);

    // fill, full blocks push, simultaneous push/pop, wrap
    for (int i = 0; i < 4; i++) begin
      fetch(1'b1, 32'h400 + 32'(4 * i), 1'b0, 32'h0); tick();
    end
    chk("t4.full_count", 32'(bus.count), 4);
    chk("t4.full_ready", 32'(bus.fetch_ready), 0);
    fetch(1'b1, 32'h410, 1'b0, 32'h0); tick();
    chk("t4.full_ignore", 32'(bus.count), 4);
    resolve(1'b1, 1'b0, 32'h0); tick();
    chk_upd("t4.pop400", 1'b1, 32'h400, 1'b0, 3);
    for (int i = 0; i < 4; i++) begin
      fetch(1'b1, 32'h410 + 32'(4 * i), 1'b0, 32'h0); tick();
      chk_upd("t4.pushpop", 1'b1, 32'h404 + 32'(4 * i), 1'b0, 3);
    end
    fetch(1'b0, '0, 1'b0, '0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk_upd("t4.drain", 1'b1, 32'h414 + 32'(4 * i), 1'b0, 32'(2 - i));
    end
    chk("t4.no_mis", 32'(bus.mispredict), 0);

    // empty resolve -> sticky underflow, no update
    tick();
    chk_upd("t5.empty", 1'b0, 32'h0, 1'b0, 0);
    chk("t5.underflow", 32'(bus.underflow_err), 1);
    resolve(1'b0, 1'b0, '0); tick();
    chk("t5.sticky", 32'(bus.underflow_err), 1);

    // pipeline_en low freezes everything
    fetch(1'b1, 32'h500, 1'b0, 32'h0); tick();
    bus.pipeline_en = 1'b0;
    fetch(1'b1, 32'h504, 1'b0, 32'h0);
    resolve(1'b1, 1'b1, 32'h600);
    tick(); tick();
    chk_upd("t5.stall", 1'b0, 32'h0, 1'b0, 1);
    chk("t5.stall_mis", 32'(bus.mispredict), 0);
    chk("t5.stall_ready", 32'(bus.fetch_ready), 1);
    bus.pipeline_en = 1'b1;
    fetch(1'b0, '0, 1'b0, '0);
    resolve(1'b1, 1'b0, 32'h0); tick(); resolve(1'b0, 1'b0, '0);
    chk_upd("t5.resume", 1'b1, 32'h500, 1'b0, 0);
    chk("t5.resume_mis", 32'(bus.mispredict), 0);

    // reset mid-operation with resolve pending
    for (int i = 0; i < 3; i++) begin
      fetch(1'b1, 32'h700 + 32'(4 * i), 1'b0, 32'h0); tick();
    end
    fetch(1'b0, '0, 1'b0, '0);
    chk("t6.count3", 32'(bus.count), 3);
    resolve(1'b1, 1'b1, 32'h800);
    reset = 1'b1; tick();
    reset = 1'b0; resolve(1'b0, 1'b0, '0);
    chk_upd("t6.rst", 1'b0, 32'h0, 1'b0, 0);
    chk("t6.mispredict", 32'(bus.mispredict), 0);
    chk("t6.redirect", bus.redirect_pc, 0);
    chk("t6.upd_pc", bus.upd_pc, 0);
    chk("t6.underflow", 32'(bus.underflow_err), 0);
    chk("t6.ready", 32'(bus.fetch_ready), 1);
    tick();
    chk_upd("t6.after", 1'b0, 32'h0, 1'b0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/branch_resolve_sequencer.md
Name: branch_resolve_sequencer

Overview:
- Sits between fetch/decode and execute; sequences all training of the local branch predictor.
- Holds an in-order queue of in-flight predicted branches (PC, predicted direction, predicted target).
- When execute resolves the oldest branch, issues exactly one registered update (PC, actual outcome) to the predictor.
- Detects mispredicts, drives the redirect PC and flushes wrong-path queue entries.

Parameters:
- DEPTH, 4, queue entries; power of two, at least 2.
- CNT_W, $clog2(DEPTH)+1, width of the occupancy counter.

Ports:
- clk  in  1  clock.
- reset  in  1  reset.
- pipeline_en  in  1  global advance enable; no push, pop or state change while low.
- fetch_valid  in  1  a branch was fetched and predicted this cycle.
- fetch_pc  in  32  branch PC.
- fetch_pred_taken  in  1  predictor direction (1 = take).
- fetch_pred_target  in  32  predicted target (don't-care if not taken).
- fetch_ready  out  1  combinational; queue can accept a push.
- resolve_valid  in  1  execute resolved the oldest in-flight branch.
- resolve_taken  in  1  actual direction.
- resolve_target  in  32  actual target.
- upd_valid  out  1  registered; one-cycle predictor update strobe.
- upd_pc  out  32  PC to train.
- upd_taken  out  1  actual outcome to train with.
- mispredict  out  1  registered; one-cycle redirect strobe.
- redirect_pc  out  32  correct next PC, valid with mispredict.
- count  out  CNT_W  current occupancy.
- underflow_err  out  1  sticky; a resolve arrived with the queue empty.

Behaviour:
- Reset (synchronous, active-high on clk): head = tail = count = 0, state = RUN.
- All registered outputs (upd_valid, upd_pc, upd_taken, mispredict, redirect_pc, underflow_err) clear to 0 on reset.
- Reset mid-operation discards all entries with no update issued.
- FSM states:
  - RUN: normal operation.
  - FLUSH: exactly one cycle after a mispredict; pushes blocked to drop wrong-path fetches.
  - FLUSH -> RUN unconditionally when pipeline_en = 1; holds while pipeline_en = 0.
- fetch_ready = (state == RUN) && (count != DEPTH).
- Push: fetch_valid && fetch_ready && pipeline_en writes {pc, pred_taken, pred_target} at tail; tail increments mod DEPTH.
- Pop: resolve_valid && pipeline_en && count != 0 reads the head entry; head increments mod DEPTH.
- Update latency is 1 cycle. The cycle after a pop:
  - upd_valid = 1, upd_pc = entry pc, upd_taken = resolve_taken.
  - upd_valid is 0 in every other cycle, including whenever pipeline_en was low.
- Mispredict condition, evaluated on pop:
  - resolve_taken != pred_taken, or
  - resolve_taken && resolve_target != pred_target.
- On mispredict:
  - Next cycle: mispredict = 1; redirect_pc = resolve_target if taken, else entry pc + 4 (32-bit wrap).
  - All younger entries are discarded: head = tail = count = 0 next cycle.
  - A push in the same cycle is dropped.
  - state -> FLUSH.
  - upd_valid still fires for the mispredicted branch.
- Correct prediction: mispredict = 0; redirect_pc holds its previous value.
- Simultaneous push and pop without mispredict: both occur and count is unchanged.
  - Allowed when full only if fetch_ready = 1; since fetch_ready = 0 when full, the push waits.
- Empty pop: resolve_valid && pipeline_en with count == 0:
  - No update is issued and queue state is unchanged.
  - underflow_err sets and stays set until reset.
- count always equals the number of valid entries; it never exceeds DEPTH and never goes below 0.

Test Plan:
- Reset, then push PC 0x100 (pred not-taken); resolve not-taken -> next cycle upd_valid = 1, upd_pc = 0x100, upd_taken = 0, mispredict = 0, count = 0.
- Push 0x200 (pred taken, target 0x240); resolve taken with target 0x280 -> mispredict = 1, redirect_pc = 0x280, upd_taken = 1; next cycle fetch_ready = 0 (FLUSH), then 1.
- Push 0x300, 0x304, 0x308 all predicted taken; resolve 0x300 not-taken -> redirect_pc = 0x304, count = 0 next cycle; 0x304 and 0x308 never produce upd_valid.
- Fill DEPTH = 4 entries -> fetch_ready = 0, further fetch_valid ignored; push and pop in the same cycle once count = 3 -> count stays 3; wrap tail past index 3 and verify FIFO order 0x400..0x41C.
- Resolve with queue empty -> no upd_valid, underflow_err = 1 and stays set; hold pipeline_en = 0 with fetch_valid = resolve_valid = 1 -> count, outputs and state unchanged.
- Assert reset with 3 entries queued and a resolve pending -> count = 0, all outputs 0 the next cycle, no upd_valid.
